// File: rtl/ext_interleaver_if.sv
// Handshake and data bundle for the extrinsic interleaver buffer: input beat
// stream from a component decoder, permuted output beat stream to the next one.
interface ext_interleaver_if #(
    parameter int W = 30
);
    logic         mode;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_1;
    logic [W-1:0] in_2;
    logic [W-1:0] in_3;
    logic [W-1:0] in_4;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_1;
    logic [W-1:0] out_2;
    logic [W-1:0] out_3;
    logic [W-1:0] out_4;
    logic         frame_done;

    modport master (
        output mode, in_valid, in_1, in_2, in_3, in_4, out_ready,
        input  in_ready, out_valid, out_1, out_2, out_3, out_4, frame_done
    );

    modport slave (
        input  mode, in_valid, in_1, in_2, in_3, in_4, out_ready,
        output in_ready, out_valid, out_1, out_2, out_3, out_4, frame_done
    );
endinterface

// File: rtl/ext_interleaver.sv
// 4-lane QPP interleaver/deinterleaver frame buffer: fills K extrinsic values,
// then drains them in permuted (mode=0) or de-permuted (mode=1) order.
module ext_interleaver #(
    parameter int K  = 40,
    parameter int F1 = 3,
    parameter int F2 = 10,
    parameter int W  = 30
) (
    input  logic              clk,
    input  logic              rst,
    ext_interleaver_if.slave  bus
);
    localparam int NB    = K / 4;
    localparam int AW    = $clog2(K);
    localparam int BW    = (NB > 1) ? $clog2(NB) : 1;
    localparam int D_INC = (32 * F2) % K;

    typedef enum logic {S_FILL, S_DRAIN} state_t;

    function automatic int pi_init(input int l);
        return (F1 * l + F2 * l * l) % K;
    endfunction

    function automatic int step_init(input int l);
        return (4 * F1 + 16 * F2 + 8 * F2 * l) % K;
    endfunction

    // Modular add with a single conditional subtract; both operands are < K.
    function automatic logic [AW-1:0] add_mod(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [AW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (AW+1)'(K))
            s = s - (AW+1)'(K);
        return s[AW-1:0];
    endfunction

    state_t          state_q, state_d;
    logic [BW-1:0]   b_q, b_d;
    logic            mode_q, mode_d;
    logic            frame_done_q, frame_done_d;
    logic [AW-1:0]   p_q    [4];
    logic [AW-1:0]   p_d    [4];
    logic [AW-1:0]   step_q [4];
    logic [AW-1:0]   step_d [4];
    logic [W-1:0]    mem_q  [K];

    logic [AW-1:0]   p_init    [4];
    logic [AW-1:0]   step_init_v [4];
    logic [AW-1:0]   seq_addr  [4];
    logic [AW-1:0]   wr_addr   [4];
    logic [AW-1:0]   rd_addr   [4];
    logic [W-1:0]    in_data   [4];
    logic [W-1:0]    out_data  [4];
    logic            wr_en;
    logic            beat_done;
    logic            last_beat;
    logic            mode_eff;

    assign last_beat = (b_q == BW'(NB - 1));
    // The first beat of a frame must already be placed using the live mode pin.
    assign mode_eff  = (state_q == S_FILL && b_q == '0) ? bus.mode : mode_q;

    assign in_data[0] = bus.in_1;
    assign in_data[1] = bus.in_2;
    assign in_data[2] = bus.in_3;
    assign in_data[3] = bus.in_4;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign p_init[gi]      = AW'(pi_init(gi));
            assign step_init_v[gi] = AW'(step_init(gi));
            assign seq_addr[gi]    = {b_q, 2'(gi)};
            assign wr_addr[gi]     = mode_eff ? p_q[gi] : seq_addr[gi];
            assign rd_addr[gi]     = mode_q ? seq_addr[gi] : p_q[gi];
            assign out_data[gi]    = (state_q == S_DRAIN) ? mem_q[rd_addr[gi]] : '0;
        end
    endgenerate

    assign bus.out_1      = out_data[0];
    assign bus.out_2      = out_data[1];
    assign bus.out_3      = out_data[2];
    assign bus.out_4      = out_data[3];
    assign bus.in_ready   = (state_q == S_FILL);
    assign bus.out_valid  = (state_q == S_DRAIN);
    assign bus.frame_done = frame_done_q;

    always_comb begin
        state_d      = state_q;
        b_d          = b_q;
        mode_d       = mode_q;
        frame_done_d = 1'b0;
        p_d          = p_q;
        step_d       = step_q;
        wr_en        = 1'b0;
        beat_done    = 1'b0;

        case (state_q)
            S_FILL: begin
                if (bus.in_valid) begin
                    wr_en     = 1'b1;
                    beat_done = 1'b1;
                    if (b_q == '0)
                        mode_d = bus.mode;
                    if (last_beat)
                        state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.out_ready) begin
                    beat_done = 1'b1;
                    if (last_beat) begin
                        state_d      = S_FILL;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: state_d = S_FILL;
        endcase

        if (beat_done) begin
            if (last_beat) begin
                b_d    = '0;
                p_d    = p_init;
                step_d = step_init_v;
            end else begin
                b_d = b_q + 1'b1;
                for (int l = 0; l < 4; l++) begin
                    p_d[l]    = add_mod(p_q[l], step_q[l]);
                    step_d[l] = add_mod(step_q[l], AW'(D_INC));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FILL;
            b_q          <= '0;
            mode_q       <= 1'b0;
            frame_done_q <= 1'b0;
            p_q          <= p_init;
            step_q       <= step_init_v;
        end else begin
            state_q      <= state_d;
            b_q          <= b_d;
            mode_q       <= mode_d;
            frame_done_q <= frame_done_d;
            p_q          <= p_d;
            step_q       <= step_d;
        end
    end

    // Storage is deliberately not reset; lanes never collide since pi is a permutation.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int l = 0; l < 4; l++)
                mem_q[wr_addr[l]] <= in_data[l];
        end
    end
endmodule

// File: tb/tb_ext_interleaver.sv
// Self-checking bench for ext_interleaver against a direct QPP reference model.
module tb_ext_interleaver;
    localparam int K  = 40;
    localparam int F1 = 3;
    localparam int F2 = 10;
    localparam int W  = 30;
    localparam int NB = K / 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ext_interleaver_if #(.W(W)) bus ();

    ext_interleaver #(.K(K), .F1(F1), .F2(F2), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int frame_no = 0;

    logic [W-1:0] in_frame  [K];
    logic [W-1:0] exp_frame [K];
    logic [W-1:0] obs_frame [K];
    logic [W-1:0] ref_frame [K];

    function automatic int pi(input int i);
        return (F1 * i + F2 * i * i) % K;
    endfunction

    task automatic build_expected(input bit m);
        for (int i = 0; i < K; i++) begin
            if (!m) exp_frame[i] = in_frame[pi(i)];
            else    exp_frame[pi(i)] = in_frame[i];
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] get_out(input int l);
        case (l)
            0:       return bus.out_1;
            1:       return bus.out_2;
            2:       return bus.out_3;
            default: return bus.out_4;
        endcase
    endfunction

    task automatic set_in(input int l, input logic [W-1:0] v);
        case (l)
            0:       bus.in_1 = v;
            1:       bus.in_2 = v;
            2:       bus.in_3 = v;
            default: bus.in_4 = v;
        endcase
    endtask

    task automatic randomize_frame();
        for (int i = 0; i < K; i++) in_frame[i] = W'($urandom);
    endtask

    task automatic fill(input bit m, input int gap_pct, input bit flip);
        int beat = 0;
        int cyc  = 0;
        while (beat < NB && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            check("fill_in_ready", 32'(bus.in_ready), 1);
            check("fill_out_valid", 32'(bus.out_valid), 0);
            check("fill_out_zero", 32'(bus.out_1), 0);
            if ($urandom_range(99) < gap_pct) begin
                bus.in_valid = 1'b0;
                for (int l = 0; l < 4; l++) set_in(l, W'($urandom));
                bus.mode = 1'($urandom_range(1));
            end else begin
                bus.in_valid = 1'b1;
                for (int l = 0; l < 4; l++) set_in(l, in_frame[4*beat+l]);
                bus.mode = (beat == 0 || !flip) ? m : 1'($urandom_range(1));
                beat++;
            end
        end
        if (beat < NB) check("fill_timeout", 32'(beat), 32'(NB));
    endtask

    task automatic drain(input int stall_pct, input bit junk, input int nbeats, output int cycles);
        int beat = 0;
        cycles = 0;
        while (beat < nbeats && cycles < 1000) begin
            @(negedge clk);
            cycles++;
            check("drain_out_valid", 32'(bus.out_valid), 1);
            check("drain_in_ready", 32'(bus.in_ready), 0);
            check("drain_done_low", 32'(bus.frame_done), 0);
            for (int l = 0; l < 4; l++)
                check($sformatf("drain_data_b%0d_l%0d", beat, l), 32'(get_out(l)), 32'(exp_frame[4*beat+l]));
            bus.out_ready = ($urandom_range(99) >= stall_pct);
            if (junk) begin
                bus.in_valid = 1'b1;
                for (int l = 0; l < 4; l++) set_in(l, W'($urandom));
                bus.mode = 1'($urandom_range(1));
            end else begin
                bus.in_valid = 1'b0;
            end
            if (bus.out_ready) begin
                for (int l = 0; l < 4; l++) obs_frame[4*beat+l] = get_out(l);
                beat++;
            end
        end
        if (beat < nbeats) check("drain_timeout", 32'(beat), 32'(nbeats));
        if (nbeats == NB) begin
            @(negedge clk);
            check("frame_done_pulse", 32'(bus.frame_done), 1);
            check("post_in_ready", 32'(bus.in_ready), 1);
            check("post_out_valid", 32'(bus.out_valid), 0);
            check("post_out_zero", 32'(bus.out_2), 0);
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b0;
            $display("frame %0d drained: %0d beats in %0d cycles", frame_no, NB, cycles);
            frame_no++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int ok;
        int qa[$];
        int qb[$];
        int beat01 [8];
        beat01 = '{0, 13, 6, 19, 12, 25, 18, 31};

        rst = 1'b1;
        bus.mode = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        for (int l = 0; l < 4; l++) set_in(l, '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_frame_done", 32'(bus.frame_done), 0);
        for (int l = 0; l < 4; l++) check($sformatf("rst_out_%0d", l), 32'(get_out(l)), 0);

        // Directed interleave of the identity sequence.
        for (int i = 0; i < K; i++) in_frame[i] = W'(i);
        build_expected(1'b0);
        fill(1'b0, 0, 1'b0);
        drain(0, 1'b0, NB, cyc);
        check("t1_drain_cycles", 32'(cyc), 32'(NB));
        for (int i = 0; i < 8; i++) check($sformatf("t1_golden_%0d", i), 32'(obs_frame[i]), 32'(beat01[i]));

        // Deinterleave the interleaved sequence back to identity.
        for (int i = 0; i < K; i++) in_frame[i] = obs_frame[i];
        build_expected(1'b1);
        fill(1'b1, 0, 1'b0);
        drain(0, 1'b0, NB, cyc);
        for (int i = 0; i < K; i++) check($sformatf("t2_identity_%0d", i), 32'(obs_frame[i]), 32'(i));

        // Backpressure: stalled drain must reproduce the unstalled sequence.
        randomize_frame();
        build_expected(1'b0);
        fill(1'b0, 0, 1'b0);
        drain(0, 1'b0, NB, cyc);
        for (int i = 0; i < K; i++) ref_frame[i] = obs_frame[i];
        fill(1'b0, 0, 1'b0);
        drain(50, 1'b0, NB, cyc);
        for (int i = 0; i < K; i++) check($sformatf("t3_same_seq_%0d", i), 32'(obs_frame[i]), 32'(ref_frame[i]));

        // Junk input during drain and mode flipping after the first beat.
        randomize_frame();
        build_expected(1'b1);
        fill(1'b1, 30, 1'b1);
        drain(30, 1'b1, NB, cyc);

        // Reset in the middle of DRAIN at beat 5.
        randomize_frame();
        build_expected(1'b0);
        fill(1'b0, 0, 1'b0);
        drain(0, 1'b0, 5, cyc);
        @(negedge clk);
        check("t5_beat5_valid", 32'(bus.out_valid), 1);
        check("t5_beat5_data", 32'(bus.out_1), 32'(exp_frame[20]));
        rst = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("t5_rst_out_valid", 32'(bus.out_valid), 0);
        check("t5_rst_in_ready", 32'(bus.in_ready), 1);
        check("t5_rst_frame_done", 32'(bus.frame_done), 0);
        check("t5_rst_out_zero", 32'(bus.out_1), 0);
        randomize_frame();
        build_expected(1'b1);
        fill(1'b1, 0, 1'b0);
        drain(0, 1'b0, NB, cyc);

        // Back-to-back frames, alternating mode, gaps and stalls.
        for (int f = 0; f < 4; f++) begin
            randomize_frame();
            build_expected(1'(f % 2));
            fill(1'(f % 2), 40, 1'b1);
            drain(20, 1'b0, NB, cyc);
            qa.delete(); qb.delete();
            for (int i = 0; i < K; i++) begin
                qa.push_back(int'(in_frame[i]));
                qb.push_back(int'(obs_frame[i]));
            end
            qa.sort(); qb.sort();
            ok = 1;
            for (int i = 0; i < K; i++) if (qa[i] != qb[i]) ok = 0;
            check($sformatf("t6_permutation_f%0d", f), 32'(ok), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ext_interleaver.md
# ext_interleaver

Extrinsic-information interleaver/deinterleaver buffer between the two component decoders of the 4-lane turbo decoder. It captures one frame of K extrinsic values, 4 lanes per beat, from a component decoder's `w1_*` outputs. It then replays the frame in permuted order as the next decoder's a-priori input (`z*_1..4`). A runtime `mode` input selects QPP interleaving (decoder 1 → decoder 2) or deinterleaving (decoder 2 → decoder 1), so one block design serves both directions of the iteration loop.

## Interface
- `K`, 40: frame length in symbols; multiple of 4; valid range 8..256.
- `F1`, 3: QPP coefficient f1; (F1, F2) must give a permutation for K.
- `F2`, 10: QPP coefficient f2.
- `W`, 30: extrinsic word width.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  1  0 = interleave, 1 = deinterleave; sampled on the first accepted input beat of a frame.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  high in FILL state.
- `in_1..in_4`  in  W each  extrinsic values for symbols 4b+0..4b+3 of beat b.
- `out_valid`  out  1  high in DRAIN state.
- `out_ready`  in  1  consumer accepts the current output beat.
- `out_1..out_4`  out  W each  permuted values for output positions 4b+0..4b+3.
- `frame_done`  out  1  one-cycle pulse after the last output beat is accepted.

## Operation
- Storage is a K×W register file. Memory contents are not reset.
- Permutation: π(i) = (F1·i + F2·i²) mod K.
- Interleave (mode=0): write mem[i] = in(i); output out(i) = mem[π(i)].
- Deinterleave (mode=1): write mem[π(i)] = in(i); output out(i) = mem[i].
- π addresses are generated recursively per lane, with no multipliers at runtime:
  - p_l starts at π(l); d_l starts at (4F1 + 16F2 + 8F2·l) mod K.
  - Per beat: p_l ← (p_l + d_l) mod K and d_l ← (d_l + 32F2 mod K) mod K.
  - Each addition uses one conditional subtract of K. Initial constants are elaboration-time functions.
- States:
  - FILL: `in_ready`=1. A beat is accepted when `in_valid`=1. The write counter b runs 0..K/4-1. The beat with b=K/4-1 transitions to DRAIN on the next cycle. The counter and p/d registers are restored to their initial values at that transition.
  - DRAIN: `in_ready`=0, `out_valid`=1. Output data is a combinational read of the register file using the sequential or π addresses. A beat completes on `out_ready`=1. The last beat (b=K/4-1) returns the block to FILL, pulses `frame_done`, and restores the counters and p/d registers.
- While `out_valid`=0, `out_1..4` are 0.
- `in_valid` is ignored while `in_ready`=0.
- `mode` is held internally until the frame's DRAIN completes. Changes to the `mode` pin mid-frame have no effect.
- Reset, including mid-FILL or mid-DRAIN, returns the block to FILL:
  - state, counters and the mode register are cleared; p/d are set to initial values.
  - `in_ready`=1, `out_valid`=0, `frame_done`=0.
  - Any partial frame is discarded.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_1..4`=0, `frame_done`=0.
- Last input beat accepted at edge t → `out_valid`=1 during cycle t+1.
- Output data is valid in the same cycle as `out_valid`. There is no read-latency cycle.
- With `out_ready` held high, one frame takes exactly K/2 cycles (K/4 FILL + K/4 DRAIN). At K=40 this is 20 cycles.
- `frame_done` is high for the single cycle after the final DRAIN handshake, coincident with `in_ready` returning to 1.
- `out_ready`=0 holds `out_1..4` and b stable for any number of cycles.
- Permuted addresses must be valid in every DRAIN cycle. Recursion registers update only on a completed beat.

## Test plan
- Interleave, K=40, in(i)=i, `out_ready`=1 → beat 0 = {0,13,6,19}, beat 1 = {12,25,18,31}. `out_valid` rises on the cycle after the 10th input beat; `frame_done` pulses 10 cycles later.
- Deinterleave of the interleaved sequence from the previous test → output = {0,1,2,…,39} in order, 4 per beat.
- Backpressure: toggle `out_ready` pseudo-randomly during DRAIN → each beat is held unchanged while `out_ready`=0; the output sequence is identical to the unstalled run.
- `in_valid`=1 with random data throughout DRAIN → `in_ready`=0 and the output is unaffected. Flip `mode` mid-frame → the frame keeps its latched mode.
- Assert `rst` for one cycle at DRAIN beat 5 → next cycle `out_valid`=0, `in_ready`=1, `frame_done`=0. A new full frame then drains correctly from beat 0.
- Back-to-back frames with alternating mode and gaps in `in_valid` → every frame matches the golden π model. The output set of each frame is a permutation of its inputs.
